vga_pixel_fifo: RTL

VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

---
 rtl/vga_pixel_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_pixel_fifo.sv
// Camera-to-VGA pixel FIFO: SOF-aligned fill, prefill threshold, registered RGB565->RGB888 output.
// Optional VGA_PIXEL_FIFO_STATS_EN adds saturating drop/underflow counters.
module vga_pixel_fifo #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned PREFILL = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWrSof,
  input  logic              iWrEn,
  input  logic [15:0]       iWrData,
  input  logic              iRequest,
  input  logic              iFrameDone,
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic [ADDR_W:0]   oLevel,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oUnderflow,
  output logic              oOverflow,
  output logic              oStreaming
`ifdef VGA_PIXEL_FIFO_STATS_EN
  ,
  output logic [15:0]       oDropCnt,
  output logic [15:0]       oUnderCnt
`endif
);

  localparam logic [ADDR_W:0] DepthLvl   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PrefillLvl = (ADDR_W + 1)'(PREFILL);

  typedef enum logic [1:0] {StWaitSof, StFill, StStream} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_pix;
  logic              flush, pop, wr, drop, under_hit;

  // Pointers carry one extra bit so the difference spans 0..DEPTH.
  assign oLevel = wr_ptr_q - rd_ptr_q;
  assign oFull  = (oLevel == DepthLvl);
  assign oEmpty = (oLevel == '0);
  assign rd_pix = mem[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    flush     = (state_q == StStream) && iFrameDone;
    pop       = (state_q == StStream) && iRequest && !oEmpty && !flush;
    under_hit = (state_q == StStream) && iRequest && oEmpty;
    wr        = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      StWaitSof: wr = iWrEn && iWrSof;
      default: begin
        // A pop on the same cycle frees the slot a full-FIFO write needs.
        wr   = iWrEn && !flush && (!oFull || pop);
        drop = iWrEn && !flush && oFull && !pop;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (wr) mem[wr_ptr_q[ADDR_W-1:0]] <= iWrData;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StWaitSof;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
      oUnderflow <= 1'b0;
      oOverflow  <= 1'b0;
      oStreaming <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitSof: if (wr) state_q <= StFill;
        StFill: begin
          if (oLevel >= PrefillLvl) begin
            state_q    <= StStream;
            oStreaming <= 1'b1;
          end
        end
        StStream: begin
          if (iFrameDone) begin
            state_q    <= StWaitSof;
            oStreaming <= 1'b0;
          end
        end
        default: state_q <= StWaitSof;
      endcase

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if (pop) begin
        oRed   <= {rd_pix[15:11], rd_pix[15:13]};
        oGreen <= {rd_pix[10:5],  rd_pix[10:9]};
        oBlue  <= {rd_pix[4:0],   rd_pix[4:2]};
      end else begin
        oRed   <= '0;
        oGreen <= '0;
        oBlue  <= '0;
      end

      if (under_hit) oUnderflow <= 1'b1;
      if (drop)      oOverflow  <= 1'b1;
    end
  end

`ifdef VGA_PIXEL_FIFO_STATS_EN
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDropCnt  <= '0;
      oUnderCnt <= '0;
    end else begin
      if (drop && oDropCnt != 16'hFFFF)       oDropCnt  <= oDropCnt + 16'd1;
      if (under_hit && oUnderCnt != 16'hFFFF) oUnderCnt <= oUnderCnt + 16'd1;
    end
  end
`endif

endmodule
